// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: blank pattern, hex glyphs
// and a width helper for counters and indices.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; b and d are the lowercase glyphs.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[hex];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed NUM_DIGITS hex display with frame-synchronous shadow updates,
// blank/blink masks and leading-zero suppression. Optional: SEG7_SCAN_DIMMING_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 10000,
    parameter int BLINK_DIV  = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    update_i,
    output logic                    update_ack_o,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    input  logic                    lz_en_i,
`ifdef SEG7_SCAN_DIMMING_EN
    input  logic [3:0]              brightness_i,
`endif
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int PRE_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int BLK_W = clog2(BLINK_DIV);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        digit_idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] staging;
    logic                    pending;
    logic                    tick;
    logic                    frame_start;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    cur_dp;
    logic                    upper_nz;
    logic                    suppressed;
    logic                    digit_off;
    logic                    dim_on;
    logic [6:0]              glyph;

    assign tick        = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frame_start = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                digit_idx <= frame_start ? '0 : digit_idx + 1'b1;
        end
    end

    // A request landing on the frame-start tick skips staging entirely.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow       <= '0;
            staging      <= '0;
            pending      <= 1'b0;
            update_ack_o <= 1'b0;
            frame_o      <= 1'b0;
        end else begin
            frame_o      <= frame_start;
            update_ack_o <= 1'b0;
            if (frame_start) begin
                if (update_i) begin
                    shadow       <= data_i;
                    pending      <= 1'b0;
                    update_ack_o <= 1'b1;
                end else if (pending) begin
                    shadow       <= staging;
                    pending      <= 1'b0;
                    update_ack_o <= 1'b1;
                end
            end else if (update_i) begin
                staging <= data_i;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        upper_nz  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nib   = shadow[4*k +: 4];
                cur_blank = blank_mask_i[k];
                cur_blink = blink_mask_i[k];
                cur_dp    = dp_mask_i[k];
            end
            if ((IDX_W'(k) >= digit_idx) && (shadow[4*k +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
    end

    assign suppressed = lz_en_i && (digit_idx != '0) && !upper_nz;
    assign digit_off  = cur_blank || (cur_blink && blink_phase) || suppressed;

`ifdef SEG7_SCAN_DIMMING_EN
    logic [3:0]  bright_q;
    logic [31:0] dim_limit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            bright_q <= 4'hF;
        else if (frame_start)
            bright_q <= brightness_i;
    end

    assign dim_limit = ((32'(bright_q) + 32'd1) * 32'(SCAN_DIV)) / 32'd16;
    assign dim_on    = (32'(prescaler) < dim_limit);
`else
    assign dim_on = 1'b1;
`endif

    seg7_hex_decoder u_dec (
        .hex (cur_nib),
        .seg (glyph)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end else if (!digit_off && dim_on) begin
            seg_o <= glyph;
            dp_o  <= ~cur_dp;
            an_o  <= ~(NUM_DIGITS'(1) << digit_idx);
        end else begin
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with NUM_DIGITS=8, SCAN_DIV=4, BLINK_DIV=2.
module tb_seg7_scan_display;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        update_i = 1'b0;
    logic        update_ack_o;
    logic [7:0]  blank_mask_i = '0;
    logic [7:0]  blink_mask_i = '0;
    logic [7:0]  dp_mask_i = '0;
    logic        lz_en_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        frame_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int ack_seen = 0;

    logic [7:0] exp_an  [8];
    logic [6:0] exp_seg [8];
    logic       exp_dp  [8];

    seg7_scan_display #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .update_i     (update_i),
        .update_ack_o (update_ack_o),
        .blank_mask_i (blank_mask_i),
        .blink_mask_i (blink_mask_i),
        .dp_mask_i    (dp_mask_i),
        .lz_en_i      (lz_en_i),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .an_o         (an_o),
        .frame_o      (frame_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (update_ack_o === 1'b1) ack_seen++;
    endtask

    task automatic pulse_update(input logic [31:0] d);
        data_i   = d;
        update_i = 1'b1;
        step();
        update_i = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_o !== 1'b1 && n < 40);
        check({tag, "_frame_seen"}, frame_o, 1);
    endtask

    task automatic set_exp(input int k, input logic lit, input logic [6:0] s);
        exp_an[k]  = lit ? ~(8'h01 << k) : 8'hFF;
        exp_seg[k] = lit ? s : 7'h7F;
        exp_dp[k]  = 1'b1;
    endtask

    // Starts right after a frame-start edge; ends right after the next one.
    task automatic walk(input string tag);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("%s_an%0d", tag, k), an_o, exp_an[k]);
            check($sformatf("%s_seg%0d", tag, k), seg_o, exp_seg[k]);
            check($sformatf("%s_dp%0d", tag, k), dp_o, exp_dp[k]);
            repeat (3) step();
        end
        check({tag, "_frame_period"}, frame_o, 1);
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #2;
        check("rst_seg", seg_o, 7'h7F);
        check("rst_an", an_o, 8'hFF);
        check("rst_dp", dp_o, 1);
        check("rst_ack", update_ack_o, 0);
        check("rst_frame", frame_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Basic update: ack at next frame start, then walk D C B A 4 3 2 1
        ack_seen = 0;
        pulse_update(32'h1234ABCD);
        check("t1_no_early_ack", update_ack_o, 0);
        wait_frame("t1");
        check("t1_ack_with_frame", update_ack_o, 1);
        check("t1_ack_count", ack_seen, 1);
        set_exp(0, 1, 7'h21); set_exp(1, 1, 7'h46); set_exp(2, 1, 7'h03); set_exp(3, 1, 7'h08);
        set_exp(4, 1, 7'h19); set_exp(5, 1, 7'h30); set_exp(6, 1, 7'h24); set_exp(7, 1, 7'h79);
        walk("t1");

        // Last write wins, single ack; decimal point on digit 1
        ack_seen  = 0;
        dp_mask_i = 8'h02;
        repeat (4) step();
        pulse_update(32'h0000_0001);
        step();
        pulse_update(32'h0000_0002);
        wait_frame("t2");
        check("t2_ack_count", ack_seen, 1);
        set_exp(0, 1, 7'h24);
        for (int k = 1; k < 8; k++) set_exp(k, 1, 7'h40);
        exp_dp[1] = 1'b0;
        walk("t2");
        dp_mask_i = 8'h00;

        // Leading-zero suppression
        lz_en_i = 1'b1;
        pulse_update(32'h0000_0050);
        wait_frame("t3a");
        set_exp(0, 1, 7'h40); set_exp(1, 1, 7'h12);
        for (int k = 2; k < 8; k++) set_exp(k, 0, 7'h7F);
        walk("t3a");
        pulse_update(32'h0000_0000);
        wait_frame("t3b");
        set_exp(1, 0, 7'h7F);
        walk("t3b");

        // Update coincident with frame-start tick bypasses staging
        ack_seen = 0;
        repeat (31) step();
        data_i   = 32'h0000_0009;
        update_i = 1'b1;
        step();
        update_i = 1'b0;
        check("t4_bypass_ack", update_ack_o, 1);
        check("t4_bypass_frame", frame_o, 1);
        check("t4_bypass_count", ack_seen, 1);
        ack_seen = 0;
        set_exp(0, 1, 7'h10);
        walk("t4");
        check("t4_no_second_ack", ack_seen, 0);
        lz_en_i = 1'b0;

        // Async reset mid-slot with a pending request
        repeat (2) step();
        pulse_update(32'h0000_00FF);
        step();
        #3 rst_i = 1'b1;
        #1;
        check("t5_async_seg", seg_o, 7'h7F);
        check("t5_async_an", an_o, 8'hFF);
        check("t5_async_dp", dp_o, 1);
        check("t5_async_ack", update_ack_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Blink: digit 0 lit two frames, dark two frames; digit 1 unaffected
        blink_mask_i = 8'h01;
        ack_seen     = 0;
        for (int f = 0; f < 4; f++) begin
            for (int c = 1; c <= 32; c++) begin
                step();
                if (c == 1) begin
                    check($sformatf("t6_d0_an_f%0d", f), an_o, (f < 2) ? 8'hFE : 8'hFF);
                    check($sformatf("t6_d0_seg_f%0d", f), seg_o, (f < 2) ? 7'h40 : 7'h7F);
                end
                if (c == 5) begin
                    check($sformatf("t6_d1_an_f%0d", f), an_o, 8'hFD);
                    check($sformatf("t6_d1_seg_f%0d", f), seg_o, 7'h40);
                end
                if (c == 32) check($sformatf("t6_frame_f%0d", f), frame_o, 1);
            end
        end
        check("t5_no_ack_after_reset", ack_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised successor of the board's 8-digit hex display path.
- Time-multiplexes NUM_DIGITS hex nibbles onto one common 7-segment bus with active-low anodes.
- Adds tear-free frame-synchronous updates, per-digit blank and blink masks, leading-zero suppression and a frame strobe.
- Sits between the top-level controller, which supplies the data word and masks, and the board pins.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits; range 1..16.
- SCAN_DIV, 10000: clk_i cycles per digit slot; must be at least 2.
- BLINK_DIV, 256: number of frames per blink half-period; must be at least 1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  4*NUM_DIGITS  hex nibbles; digit k = data_i[4k+3:4k]; digit 0 is rightmost.
- update_i  in  1  one-cycle request to load data_i into the display shadow.
- update_ack_o  out  1  one-cycle pulse when the shadow is actually loaded.
- blank_mask_i  in  NUM_DIGITS  1 = digit always off.
- blink_mask_i  in  NUM_DIGITS  1 = digit off during blink phase 1.
- dp_mask_i  in  NUM_DIGITS  1 = decimal point lit on that digit.
- lz_en_i  in  1  enable leading-zero suppression.
- seg_o  out  7  segments {CG..CA}, active-low.
- dp_o  out  1  decimal point, active-low.
- an_o  out  NUM_DIGITS  anodes, active-low, at most one low.
- frame_o  out  1  one-cycle pulse at every frame start.

Behaviour:
- Reset (asynchronous, active-high):
  - prescaler = 0, digit_idx = 0, blink_cnt = 0, blink_phase = 0.
  - shadow = 0, pending = 0.
  - seg_o = 7'h7F, dp_o = 1, an_o = all ones.
  - update_ack_o = 0, frame_o = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted for the cycle in which prescaler == SCAN_DIV-1.
- Digit index:
  - On tick, digit_idx advances and wraps from NUM_DIGITS-1 to 0.
  - The wrap to 0 is the frame start.
- frame_o: registered pulse, high for the one cycle after the frame-start tick.
- Update handshake:
  - update_i sets pending and captures data_i into a staging register.
  - A later update_i before the next frame start overwrites the staging register (last write wins).
  - At frame start with pending = 1: shadow <= staging, pending <= 0, and update_ack_o pulses in the same cycle as frame_o.
  - update_i coincident with the frame-start tick: data_i bypasses staging and goes straight into shadow; ack pulses; pending ends at 0.
  - Maximum latency from update_i to ack is one frame: NUM_DIGITS*SCAN_DIV cycles.
- Blink:
  - blink_cnt counts frames 0..BLINK_DIV-1.
  - blink_phase toggles when blink_cnt wraps.
- Leading-zero suppression:
  - When lz_en_i = 1, a digit k > 0 is suppressed if shadow nibble k and every nibble above it are 0.
  - Digit 0 is never suppressed, so value 0 displays as a single "0".
- Digit off condition: blank_mask_i[k], or (blink_mask_i[k] and blink_phase), or suppressed.
- Output registers:
  - Updated one cycle after digit_idx changes.
  - Digit on: an_o has a single 0 at position digit_idx; seg_o = decode(nibble); dp_o = ~dp_mask_i[idx].
  - Digit off: an_o = all ones, seg_o = 7'h7F, dp_o = 1.
- Hex decoding: standard 0-9 and A-F glyphs (b and d lowercase).
- Reset during an update: the pending request is discarded and no ack is issued.

Optional Feature:
- Macro: SEG7_SCAN_DIMMING_EN.
- When defined:
  - Adds input brightness_i [3:0].
  - Within each digit slot, the anode is enabled only while the prescaler is below (brightness_i+1)*SCAN_DIV/16, integer division.
  - brightness_i = 15 gives full on.
  - The comparison uses the registered brightness value, which is sampled at frame start.
- When undefined: no brightness port; anodes stay on for the whole slot.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF = 7'h7F.
  - The 16-entry hex glyph constants.
  - An index-width function clog2 for NUM_DIGITS and SCAN_DIV.
- Sub-module seg7_hex_decoder: combinational, 4-bit in, 7-bit active-low out, shared with other display blocks.

Test Plan:
- NUM_DIGITS=8, SCAN_DIV=4; pulse update_i with data_i=32'h1234ABCD:
  - ack arrives at the next frame start.
  - Over the following frame, an_o walks FE, FD, ... 7F.
  - seg_o shows D, C, B, A, 4, 3, 2, 1.
- update_i mid-frame with 32'h0000_0001, then again two cycles later with 32'h0000_0002 → only one ack; the shadow shows 2.
- lz_en_i=1, data 32'h0000_0050 → digits 7..2 have an_o high; digit 1 = "5"; digit 0 = "0". data 32'h0 → only digit 0 lit.
- BLINK_DIV=2, blink_mask_i=8'h01 → digit 0 is lit for 2 frames and dark for 2 frames repeatedly; the other digits are unaffected.
- Assert rst_i asynchronously mid-slot with pending=1 → outputs reach their reset values without waiting for a clock edge; no ack follows after release.
- SEG7_SCAN_DIMMING_EN, SCAN_DIV=16, brightness_i=3 → each anode is low for 4 of 16 cycles per slot.
